interrupt_ctrl: RTL and testbench

Interrupt controller that consumes the periodic tick from the interrupt generator (and up to seven further event sources) and presents one maskable, acknowledged interrupt line to the kernel's soft processor. It edge-detects each source, latches events into a pending register, prioritises, holds the request until acknowledged, and tracks the in-service source until firmware clears it. A small register interface exposes pending, mask, in-service ID and a lost-event counter.

---
 rtl/interrupt_ctrl.sv | 133 +++++++++++++
 tb/tb_interrupt_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl.sv
// Edge-detecting, maskable interrupt controller with acknowledge/service tracking
// and a small register interface (pending, mask, in-service ID, dropped-event count).
module interrupt_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [1:0]         reg_addr,
    input  logic [7:0]         reg_wdata,
    input  logic               reg_we,
    output logic [7:0]         reg_rdata,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         active_id_reg, active_id_next;
    logic [NUM_SRC-1:0] src_q_reg;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [NUM_SRC-1:0] mask_reg;
    logic [7:0]         dropped_reg, dropped_next;
    logic [7:0]         rdata_next;

    logic [NUM_SRC-1:0] event_vec;
    logic [NUM_SRC-1:0] w1c_vec;
    logic [NUM_SRC-1:0] drop_vec;
    logic [NUM_SRC-1:0] req_vec;
    logic [3:0]         drop_cnt;
    logic [8:0]         dropped_sum;
    logic [2:0]         win_id;
    logic [7:0]         pend8, mask8, active8;
    logic               unused_wdata;

    assign unused_wdata = ^reg_wdata;
    assign event_vec    = irq_src & ~src_q_reg;
    assign w1c_vec      = (reg_we && reg_addr == 2'd0) ? reg_wdata[NUM_SRC-1:0] : '0;
    assign req_vec      = pending_reg & mask_reg;

    // Set beats clear; a redundant event is one landing on a bit that stays set anyway.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_bit
            assign pending_next[gi] = event_vec[gi] | (pending_reg[gi] & ~w1c_vec[gi]);
            assign drop_vec[gi]     = event_vec[gi] & pending_reg[gi] & ~w1c_vec[gi];
        end
    endgenerate

    always_comb begin
        drop_cnt = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_cnt = drop_cnt + {3'b000, drop_vec[i]};
        end
        dropped_sum = {1'b0, dropped_reg} + {5'b00000, drop_cnt};
        if (reg_we && reg_addr == 2'd3) begin
            dropped_next = 8'h00;
        end else if (dropped_sum[8]) begin
            dropped_next = 8'hFF;
        end else begin
            dropped_next = dropped_sum[7:0];
        end
    end

    always_comb begin
        pend8                = 8'h00;
        mask8                = 8'h00;
        pend8[NUM_SRC-1:0]   = pending_reg;
        mask8[NUM_SRC-1:0]   = mask_reg;
        active8              = (state_reg == ST_SERVICE) ? {1'b1, 4'b0000, active_id_reg} : 8'h00;
        case (reg_addr)
            2'd0:    rdata_next = pend8;
            2'd1:    rdata_next = mask8;
            2'd2:    rdata_next = active8;
            default: rdata_next = dropped_reg;
        endcase
    end

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_id = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) win_id = 3'(i);
        end
    end

    always_comb begin
        state_next     = state_reg;
        active_id_next = active_id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_vec != '0) begin
                    state_next     = ST_ASSERT;
                    active_id_next = win_id;
                end
            end
            ST_ASSERT: begin
                if (interrupt_ack) state_next = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (!pend8[active_id_reg]) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign interrupt = (state_reg == ST_ASSERT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            active_id_reg <= 3'd0;
            src_q_reg     <= '0;
            pending_reg   <= '0;
            mask_reg      <= '0;
            dropped_reg   <= 8'h00;
            reg_rdata     <= 8'h00;
        end else begin
            state_reg     <= state_next;
            active_id_reg <= active_id_next;
            src_q_reg     <= irq_src;
            pending_reg   <= pending_next;
            if (reg_we && reg_addr == 2'd1) mask_reg <= reg_wdata[NUM_SRC-1:0];
            dropped_reg   <= dropped_next;
            reg_rdata     <= rdata_next;
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: a behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_src = 4'h0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic       reg_we = 1'b0;
    logic [7:0] reg_rdata;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    // model state
    logic [3:0] m_prev = 4'h0, m_pend = 4'h0, m_mask = 4'h0;
    int         m_drop = 0;
    bit         m_req = 0, m_svc = 0;
    int         m_id = 0;
    logic       m_int = 1'b0;
    logic [7:0] m_rd = 8'h00;

    interrupt_ctrl #(.NUM_SRC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_src      (irq_src),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_rdata    (reg_rdata),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_step(input logic [3:0] s, input logic [1:0] a, input logic [7:0] wd,
                              input logic we, input logic ack, input logic rst);
        logic [3:0] ev, w1c, req;
        int n;
        if (rst) begin
            m_prev = 0; m_pend = 0; m_mask = 0; m_drop = 0;
            m_req = 0; m_svc = 0; m_id = 0; m_int = 0; m_rd = 0;
            return;
        end
        case (a)
            2'd0: m_rd = {4'h0, m_pend};
            2'd1: m_rd = {4'h0, m_mask};
            2'd2: m_rd = m_svc ? (8'h80 | 8'(m_id)) : 8'h00;
            default: m_rd = 8'(m_drop);
        endcase
        ev = s & ~m_prev;
        m_prev = s;
        w1c = (we && a == 2'd0) ? wd[3:0] : 4'h0;
        n = 0;
        for (int i = 0; i < 4; i++) if (ev[i] && m_pend[i] && !w1c[i]) n++;
        req = m_pend & m_mask;
        if (!m_req && !m_svc) begin
            if (req != 0) begin
                m_req = 1;
                for (int i = 3; i >= 0; i--) if (req[i]) m_id = i;
            end
        end else if (m_req) begin
            if (ack) begin m_req = 0; m_svc = 1; end
        end else if (!m_pend[m_id]) begin
            m_svc = 0;
        end
        m_pend = ev | (m_pend & ~w1c);
        if (we && a == 2'd1) m_mask = wd[3:0];
        if (we && a == 2'd3) m_drop = 0;
        else m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
        m_int = m_req;
    endtask

    task automatic cyc(input logic [3:0] s, input logic [1:0] a, input logic [7:0] wd,
                       input logic we, input logic ack, input logic rst);
        irq_src = s; reg_addr = a; reg_wdata = wd; reg_we = we;
        interrupt_ack = ack; reset = rst;
        @(posedge clk);
        model_step(s, a, wd, we, ack, rst);
        #1;
        check("interrupt", {7'd0, interrupt}, {7'd0, m_int});
        check("reg_rdata", reg_rdata, m_rd);
        $display("t=%0t src=%h addr=%0d we=%0b wd=%02h ack=%0b rst=%0b -> irq=%0b rdata=%02h",
                 $time, s, a, we, wd, ack, rst, interrupt, reg_rdata);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cyc(4'h0, a, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cyc(4'h0, a, d, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset
        cyc(4'h0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(4'h0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_irq", {7'd0, interrupt}, 8'h00);
        check("rst_rdata", reg_rdata, 8'h00);

        // single tick, 2-cycle pulse
        wr(2'd1, 8'h01);
        cyc(4'h1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("lat_irq_low", {7'd0, interrupt}, 8'h00);
        cyc(4'h1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("lat_irq_high", {7'd0, interrupt}, 8'h01);
        check("pend_01", reg_rdata, 8'h01);
        cyc(4'h0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ack_drop", {7'd0, interrupt}, 8'h00);
        idle(1, 2'd2);
        check("active_80", reg_rdata, 8'h80);
        cyc(4'h0, 2'd0, 8'h01, 1'b1, 1'b0, 1'b0);
        idle(2, 2'd2);
        check("active_00", reg_rdata, 8'h00);
        idle(1, 2'd3);
        check("no_drop", reg_rdata, 8'h00);

        // simultaneous events on 1 and 2
        wr(2'd1, 8'h0F);
        cyc(4'h6, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1, 2'd2);
        cyc(4'h0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd2);
        check("active_81", reg_rdata, 8'h81);
        cyc(4'h0, 2'd0, 8'h02, 1'b1, 1'b0, 1'b0);
        idle(2, 2'd2);
        check("second_irq", {7'd0, interrupt}, 8'h01);
        cyc(4'h0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd2);
        check("active_82", reg_rdata, 8'h82);
        cyc(4'h0, 2'd0, 8'h04, 1'b1, 1'b0, 1'b0);
        idle(2, 2'd0);

        // three src0 pulses, no clear
        for (int i = 0; i < 3; i++) begin
            cyc(4'h1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
            idle(1, 2'd0);
        end
        idle(1, 2'd3);
        check("dropped_2", reg_rdata, 8'h02);
        idle(1, 2'd0);
        check("pend_after_drops", reg_rdata, 8'h01);
        wr(2'd3, 8'h5A);
        idle(1, 2'd3);
        check("dropped_clr", reg_rdata, 8'h00);
        cyc(4'h0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(4'h0, 2'd0, 8'h01, 1'b1, 1'b0, 1'b0);
        idle(2, 2'd0);

        // masked source, then unmask
        wr(2'd1, 8'h00);
        cyc(4'h8, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(2, 2'd0);
        check("pend_08", reg_rdata, 8'h08);
        check("masked_irq", {7'd0, interrupt}, 8'h00);
        wr(2'd1, 8'h08);
        idle(1, 2'd2);
        check("unmask_irq", {7'd0, interrupt}, 8'h01);
        cyc(4'h0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(4'h0, 2'd0, 8'h08, 1'b1, 1'b0, 1'b0);
        idle(2, 2'd0);

        // event and W1C on the same bit
        wr(2'd1, 8'h00);
        cyc(4'h2, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1, 2'd0);
        cyc(4'h2, 2'd0, 8'h02, 1'b1, 1'b0, 1'b0);
        idle(1, 2'd0);
        check("set_wins", reg_rdata, 8'h02);
        idle(1, 2'd3);
        check("set_wins_nodrop", reg_rdata, 8'h00);

        // reset while asserting
        wr(2'd1, 8'h02);
        idle(1, 2'd1);
        check("pre_rst_irq", {7'd0, interrupt}, 8'h01);
        cyc(4'h0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("midrst_irq", {7'd0, interrupt}, 8'h00);
        for (int a = 0; a < 4; a++) begin
            cyc(4'h0, 2'(a), 8'h00, 1'b0, 1'b0, 1'b0);
            check("post_rst_reg", reg_rdata, 8'h00);
        end
        idle(2, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
